// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem request FSM and a
// prefetch FIFO presenting {instr, pc} to decode; redirect flushes everything in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          drop_q, drop_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, valid_q;
  entry_t        head_q, head_d;
  logic          push, pop, credit;

  // Next-state: FIFO bookkeeping, request FSM, then redirect overriding both
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;

    push = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;
    pop  = valid_q && instr_ready && !redirect;

    if (push) begin
      mem_d[wr_q] = '{pc: req_pc_q, word: imem_rdata};
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Credit counts the post-update occupancy; nothing is outstanding when this is used
    credit = (cnt_d < CW'(DEPTH));

    case (state_q)
      S_IDLE: begin
        if (credit) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = credit ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
      if (((state_q == S_WAIT) && !imem_rvalid) || ((state_q == S_REQ) && imem_gnt)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end

    head_d = (cnt_d != '0) ? mem_d[rd_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      req_q      <= (state_d == S_REQ);
      valid_q    <= (cnt_d != '0);
      head_q     <= head_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr       = head_q.word;
  assign instr_pc    = head_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, fetch-stream reference model,
// directed redirect table and randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] XORK     = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: grants with probability gnt_pct, answers each grant in order after lat cycles
  typedef struct { logic [31:0] addr; int due; } resp_t;
  resp_t       pend[$];
  bit          manual  = 0;
  int unsigned gnt_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (!rst_n) begin
          pend.delete();
          imem_gnt = 1'b0; imem_rvalid = 1'b0;
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
          if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ XORK;
            void'(pend.pop_front());
          end
          imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
          if (imem_gnt) pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        end
      end
    end
  end

  // Reference: decode sees a contiguous PC stream restarting at each redirect target
  bit          mon_en = 1;
  logic [31:0] exp_next_pc, exp_fetch, prev_addr, first_pc;
  bit          prev_req, prev_gnt, prev_redir, got_first;
  int          outstanding;
  int          deliveries = 0;

  task automatic mon_reset();
    exp_next_pc = RESET_PC; exp_fetch = RESET_PC; prev_addr = '0; first_pc = '0;
    prev_req = 0; prev_gnt = 0; prev_redir = 0; got_first = 1; outstanding = 0;
  endtask

  initial begin
    mon_reset();
    forever begin
      @(negedge clk); #2;
      if (mon_en && !rst_n) mon_reset();
      else if (mon_en) begin
        if (prev_redir) check("valid_after_redirect", 32'(instr_valid), 32'd0);
        if (!instr_valid) begin
          check("empty_instr", instr, 32'd0);
          check("empty_pc", instr_pc, 32'd0);
        end else begin
          check("head_pc", instr_pc, exp_next_pc);
          check("head_data", instr, exp_next_pc ^ XORK);
          if (!got_first) begin got_first = 1; first_pc = instr_pc; end
        end
        if (prev_req && !prev_gnt && !prev_redir) begin
          check("req_held", 32'(imem_req), 32'd1);
          check("addr_held", imem_addr, prev_addr);
        end
        if (imem_req) check("single_outstanding", 32'(outstanding), 32'd0);
        if (imem_req && imem_gnt) begin
          check("grant_addr", imem_addr, exp_fetch);
          exp_fetch += 32'd4;
          outstanding++;
        end
        if (imem_rvalid && outstanding > 0) outstanding--;
        if (instr_valid && instr_ready && !redirect) begin
          exp_next_pc += 32'd4;
          deliveries++;
        end
        if (redirect) begin
          exp_next_pc = redirect_pc & ~32'h3;
          exp_fetch   = redirect_pc & ~32'h3;
          got_first   = 0;
        end
        prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr; prev_redir = redirect;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_grant(string name, output logic [31:0] addr);
    bit found;
    found = 0;
    addr  = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && imem_gnt) begin found = 1; addr = imem_addr; end
      else tick();
    end
    check({name, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  typedef struct {
    logic [31:0] rpc;
    int unsigned lat;
    logic [31:0] a0;
    logic [31:0] a1;
  } redir_vec_t;
  redir_vec_t vecs[4];

  initial begin
    logic [31:0] a, h;
    int g, v, d0;
    vecs[0] = '{32'h0000_0103, 3, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h7FFF_FFFF, 2, 32'h7FFF_FFFC, 32'h8000_0000};
    vecs[3] = '{32'h0000_0002, 4, 32'h0000_0000, 32'h0000_0004};

    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First word: valid two cycles after its grant, at RESET_PC
    g = -1; v = -1;
    for (int i = 0; i < 40 && v < 0; i++) begin
      tick();
      if (g < 0 && imem_req && imem_gnt) g = cyc;
      if (v < 0 && instr_valid) v = cyc;
    end
    check("first_valid_latency", 32'(v - g), 32'd2);
    check("first_pc", instr_pc, RESET_PC);
    repeat (10) tick();

    // Backpressure: FIFO fills to DEPTH and fetching stops
    instr_ready = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 8; i++) begin
      check("full_no_req", 32'(imem_req), 32'd0);
      check("full_valid", 32'(instr_valid), 32'd1);
      tick();
    end
    h = exp_next_pc;
    instr_ready = 1'b1;
    tick();
    check("drain_second_valid", 32'(instr_valid), 32'd1);
    check("drain_second_pc", instr_pc, h + 32'd4);
    tick();
    check("only_two_buffered", 32'(instr_valid), 32'd0);
    repeat (10) tick();

    // Redirect while waiting on a response, various latencies and targets
    foreach (vecs[n]) begin
      lat_min = vecs[n].lat; lat_max = vecs[n].lat;
      tick();
      wait_grant("pre_redirect_grant", a);
      tick();
      redirect = 1'b1; redirect_pc = vecs[n].rpc;
      tick();
      redirect = 1'b0;
      wait_grant("redir_grant0", a);
      check("redir_addr0", a, vecs[n].a0);
      tick();
      wait_grant("redir_grant1", a);
      check("redir_addr1", a, vecs[n].a1);
      for (int i = 0; i < 20 && !got_first; i++) tick();
      check("redir_first_seen", 32'(got_first), 32'd1);
      check("redir_first_pc", first_pc, vecs[n].a0);
      repeat (5) tick();
    end

    // Redirect coinciding with a pop on a full FIFO
    lat_min = 1; lat_max = 1; instr_ready = 1'b0;
    repeat (15) tick();
    check("popredir_full", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("popredir_flush", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("popredir_pc", instr_pc, 32'h0000_0200);
    repeat (5) tick();

    // Grant withheld: request held stable, then redirected mid-stall
    gnt_pct = 0;
    tick();
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    check("stall_req_seen", 32'(imem_req), 32'd1);
    a = exp_fetch;
    check("stall_addr", imem_addr, a);
    repeat (5) begin
      tick();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr_hold", imem_addr, a);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    check("stall_redir_req", 32'(imem_req), 32'd1);
    check("stall_redir_addr", imem_addr, 32'h0000_0300);
    gnt_pct = 100;
    repeat (10) tick();

    // Reset during WAIT, then a late response that must be ignored
    gnt_pct = 0;
    tick();
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    manual = 1; mon_en = 0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_ignored", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, RESET_PC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("post_rst_wait", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = RESET_PC ^ XORK;
    tick();
    imem_rvalid = 1'b0;
    check("post_rst_valid", 32'(instr_valid), 32'd1);
    check("post_rst_pc", instr_pc, RESET_PC);
    check("post_rst_instr", instr, RESET_PC ^ XORK);

    rst_n = 1'b0; manual = 0; mon_en = 1; gnt_pct = 100;
    tick(); tick();
    rst_n = 1'b1;

    // Randomized traffic against the stream model
    d0 = deliveries;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      instr_ready = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0; instr_ready = 1'b1;
    repeat (20) tick();
    check("random_progress", 32'((deliveries - d0) >= 50), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
